// File: rtl/eth_frame_launcher.sv
`default_nettype none
// ============================================================================
// Module      : eth_frame_launcher
// Description : Writes the 14-byte Ethernet header into the eth BRAM, waits for
//               eth_tx2 to go idle, then issues a start strobe with a clamped
//               frame length. Counts requests dropped while busy.
//               Optional macro ETH_FRAME_LAUNCHER_SEQ_EN replaces header bytes
//               10..11 with a 16-bit frame sequence number.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_frame_launcher #(
    parameter logic [47:0] DST_MAC       = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC       = 48'h0200_0000_0001,
    parameter logic [15:0] ETHERTYPE     = 16'h88B5,
    parameter int          MIN_LEN       = 60,
    parameter int          MAX_LEN       = 1024,
    parameter int          START_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_stb,
    input  logic [10:0] req_len,
    output logic        busy,
    output logic        done_stb,
    output logic        bram_wr_en,
    output logic [9:0]  bram_wr_addr,
    output logic [7:0]  bram_wr_data,
    output logic        tx_start_stb,
    output logic [10:0] tx_len,
    input  logic        tx_busy,
    output logic [7:0]  drop_cnt
);

    localparam int               c_TMO_W    = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(START_TIMEOUT - 1);
    localparam logic [3:0]       c_HDR_LAST = 4'd13;
    localparam logic [10:0]      c_MIN_LEN  = 11'(MIN_LEN);
    localparam logic [10:0]      c_MAX_LEN  = 11'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_HDR       = 3'd1,
        S_WAIT_IDLE = 3'd2,
        S_START     = 3'd3,
        S_WAIT_BUSY = 3'd4
    } state_t;

    state_t               r_state_q,   w_state_d;
    logic [3:0]           r_idx_q,     w_idx_d;
    logic [10:0]          r_len_q,     w_len_d;
    logic [c_TMO_W-1:0]   r_tmo_q,     w_tmo_d;
    logic                 r_busy_q,    w_busy_d;
    logic                 r_done_q,    w_done_d;
    logic                 r_wr_en_q,   w_wr_en_d;
    logic [9:0]           r_wr_addr_q, w_wr_addr_d;
    logic [7:0]           r_wr_data_q, w_wr_data_d;
    logic                 r_start_q,   w_start_d;
    logic [10:0]          r_tx_len_q,  w_tx_len_d;
    logic [7:0]           r_drop_q,    w_drop_d;

    logic [111:0]         w_hdr;
    logic [3:0]           w_hdr_idx;
    logic [7:0]           w_hdr_byte;
    logic [10:0]          w_len_clamped;
    logic                 w_accept;
    logic                 w_drop;

`ifdef ETH_FRAME_LAUNCHER_SEQ_EN
    logic [15:0]          r_seq_q, w_seq_d;
    assign w_hdr = {DST_MAC, SRC_MAC[47:16], r_seq_q, ETHERTYPE};
`else
    assign w_hdr = {DST_MAC, SRC_MAC, ETHERTYPE};
`endif

    // Byte to present on the next write: 0 when launching, else the following index.
    assign w_hdr_idx  = (r_state_q == S_HDR && r_idx_q != c_HDR_LAST) ? r_idx_q + 4'd1 : 4'd0;
    assign w_hdr_byte = w_hdr[7'd104 - {w_hdr_idx, 3'b000} +: 8];

    // A request coinciding with done_stb is refused even though busy is already low.
    assign w_accept = req_stb && (r_state_q == S_IDLE) && !r_done_q;
    assign w_drop   = req_stb && !w_accept;

    always_comb begin
        if (req_len > c_MAX_LEN) begin
            w_len_clamped = c_MAX_LEN;
        end else if (req_len < c_MIN_LEN) begin
            w_len_clamped = c_MIN_LEN;
        end else begin
            w_len_clamped = req_len;
        end
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_idx_d     = r_idx_q;
        w_len_d     = r_len_q;
        w_tmo_d     = r_tmo_q;
        w_done_d    = 1'b0;
        w_wr_en_d   = 1'b0;
        w_wr_addr_d = 10'd0;
        w_wr_data_d = 8'd0;
        w_start_d   = 1'b0;
        w_tx_len_d  = r_tx_len_q;
        w_drop_d    = (w_drop && r_drop_q != 8'hFF) ? r_drop_q + 8'd1 : r_drop_q;
`ifdef ETH_FRAME_LAUNCHER_SEQ_EN
        w_seq_d     = r_seq_q;
`endif
        case (r_state_q)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_d   = S_HDR;
                    w_idx_d     = 4'd0;
                    w_len_d     = w_len_clamped;
                    w_wr_en_d   = 1'b1;
                    w_wr_addr_d = 10'd0;
                    w_wr_data_d = w_hdr_byte;
                end
            end
            S_HDR: begin
                if (r_idx_q == c_HDR_LAST) begin
                    w_state_d = S_WAIT_IDLE;
                end else begin
                    w_idx_d     = w_hdr_idx;
                    w_wr_en_d   = 1'b1;
                    w_wr_addr_d = {6'd0, w_hdr_idx};
                    w_wr_data_d = w_hdr_byte;
                end
            end
            S_WAIT_IDLE: begin
                if (!tx_busy) begin
                    w_state_d  = S_START;
                    w_start_d  = 1'b1;
                    w_tx_len_d = r_len_q;
`ifdef ETH_FRAME_LAUNCHER_SEQ_EN
                    w_seq_d    = r_seq_q + 16'd1;
`endif
                end
            end
            S_START: begin
                w_state_d = S_WAIT_BUSY;
                w_tmo_d   = '0;
            end
            S_WAIT_BUSY: begin
                // A missing tx_busy acknowledgement is tolerated, not flagged.
                if (tx_busy || r_tmo_q == c_TMO_LAST) begin
                    w_state_d = S_IDLE;
                    w_done_d  = 1'b1;
                end else begin
                    w_tmo_d = r_tmo_q + c_TMO_W'(1);
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
        w_busy_d = (w_state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= S_IDLE;
            r_idx_q     <= 4'd0;
            r_len_q     <= 11'd0;
            r_tmo_q     <= '0;
            r_busy_q    <= 1'b0;
            r_done_q    <= 1'b0;
            r_wr_en_q   <= 1'b0;
            r_wr_addr_q <= 10'd0;
            r_wr_data_q <= 8'd0;
            r_start_q   <= 1'b0;
            r_tx_len_q  <= 11'd0;
            r_drop_q    <= 8'd0;
        end else begin
            r_state_q   <= w_state_d;
            r_idx_q     <= w_idx_d;
            r_len_q     <= w_len_d;
            r_tmo_q     <= w_tmo_d;
            r_busy_q    <= w_busy_d;
            r_done_q    <= w_done_d;
            r_wr_en_q   <= w_wr_en_d;
            r_wr_addr_q <= w_wr_addr_d;
            r_wr_data_q <= w_wr_data_d;
            r_start_q   <= w_start_d;
            r_tx_len_q  <= w_tx_len_d;
            r_drop_q    <= w_drop_d;
        end
    end

`ifdef ETH_FRAME_LAUNCHER_SEQ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seq_q <= 16'd0;
        end else begin
            r_seq_q <= w_seq_d;
        end
    end
`endif

    assign busy         = r_busy_q;
    assign done_stb     = r_done_q;
    assign bram_wr_en   = r_wr_en_q;
    assign bram_wr_addr = r_wr_addr_q;
    assign bram_wr_data = r_wr_data_q;
    assign tx_start_stb = r_start_q;
    assign tx_len       = r_tx_len_q;
    assign drop_cnt     = r_drop_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_frame_launcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_eth_frame_launcher
// Description : Directed bench for eth_frame_launcher with a write/length
//               scoreboard. Honours ETH_FRAME_LAUNCHER_SEQ_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_frame_launcher;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_stb;
    logic [10:0] req_len;
    logic        busy;
    logic        done_stb;
    logic        bram_wr_en;
    logic [9:0]  bram_wr_addr;
    logic [7:0]  bram_wr_data;
    logic        tx_start_stb;
    logic [10:0] tx_len;
    logic        tx_busy;
    logic [7:0]  drop_cnt;

    always #5 clk = ~clk;

    eth_frame_launcher u_dut (
        .clk          (clk),
        .rst          (rst),
        .req_stb      (req_stb),
        .req_len      (req_len),
        .busy         (busy),
        .done_stb     (done_stb),
        .bram_wr_en   (bram_wr_en),
        .bram_wr_addr (bram_wr_addr),
        .bram_wr_data (bram_wr_data),
        .tx_start_stb (tx_start_stb),
        .tx_len       (tx_len),
        .tx_busy      (tx_busy),
        .drop_cnt     (drop_cnt)
    );

    typedef struct {
        logic [9:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t         exp_wr[$];
    logic [10:0] exp_len[$];
    logic [15:0] exp_seq;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t_req   = 0;
    int n_start = 0;
    int n_done  = 0;
    int start_cyc = 0;
    int done_cyc  = 0;
    int wr0_cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int i);
        case (i)
            0, 1, 2, 3, 4, 5: return 8'hFF;
            6:                return 8'h02;
            7, 8, 9:          return 8'h00;
`ifdef ETH_FRAME_LAUNCHER_SEQ_EN
            10:               return exp_seq[15:8];
            11:               return exp_seq[7:0];
`else
            10:               return 8'h00;
            11:               return 8'h01;
`endif
            12:               return 8'h88;
            13:               return 8'hB5;
            default:          return 8'h00;
        endcase
    endfunction

    task automatic push_frame(input logic [10:0] l);
        wr_t e;
        for (int i = 0; i < 14; i++) begin
            e.addr = 10'(i);
            e.data = exp_byte(i);
            exp_wr.push_back(e);
        end
        exp_len.push_back(l);
    endtask

    // Samples DUT outputs on the falling edge and scores them, then returns for driving.
    task automatic step();
        wr_t e;
        @(negedge clk);
        if (bram_wr_en) begin
            check("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
            if (exp_wr.size() != 0) begin
                e = exp_wr.pop_front();
                check("wr_addr", 32'(bram_wr_addr), 32'(e.addr));
                check("wr_data", 32'(bram_wr_data), 32'(e.data));
            end
            if (bram_wr_addr == 10'd0) wr0_cyc = cyc;
        end
        if (tx_start_stb) begin
            n_start++;
            start_cyc = cyc;
            check("start_expected", 32'(exp_len.size() != 0), 32'd1);
            if (exp_len.size() != 0) check("tx_len", 32'(tx_len), 32'(exp_len.pop_front()));
        end
        if (done_stb) begin
            n_done++;
            done_cyc = cyc;
        end
    endtask

    task automatic send_req(input logic [10:0] len);
        step();
        req_stb = 1'b1;
        req_len = len;
        t_req   = cyc;
        step();
        req_stb = 1'b0;
    endtask

    task automatic wait_start(input int prev, input int limit);
        int k = 0;
        while (n_start == prev && k < limit) begin
            step();
            k++;
        end
        check("start_seen", 32'(n_start != prev), 32'd1);
    endtask

    task automatic wait_done(input int prev, input int limit);
        int k = 0;
        while (n_done == prev && k < limit) begin
            step();
            k++;
        end
        check("done_seen", 32'(n_done != prev), 32'd1);
    endtask

    task automatic launch_normal(input logic [10:0] len, input logic [10:0] elen, input bit drop_at_done);
        int s0 = n_start;
        int d0 = n_done;
        push_frame(elen);
        send_req(len);
        wait_start(s0, 40);
        check("start_latency", 32'(start_cyc - t_req), 32'd16);
        check("wr0_latency", 32'(wr0_cyc - t_req), 32'd1);
        tx_busy = 1'b1;
        wait_done(d0, 10);
        check("done_latency", 32'(done_cyc - start_cyc), 32'd2);
        check("idle_at_done", 32'(busy), 32'd0);
        if (drop_at_done) begin
            req_stb = 1'b1;
            req_len = 11'd100;
        end
        step();
        req_stb = 1'b0;
        exp_seq++;
        repeat (2) step();
        tx_busy = 1'b0;
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no completion expected finish");
        $fatal(1);
    end

    initial begin
        int s0;
        int d0;
        int f;
        rst     = 1'b1;
        req_stb = 1'b0;
        req_len = 11'd0;
        tx_busy = 1'b0;
        exp_seq = 16'd0;
        repeat (3) step();
        check("rst_busy",     32'(busy),         32'd0);
        check("rst_done",     32'(done_stb),     32'd0);
        check("rst_wr_en",    32'(bram_wr_en),   32'd0);
        check("rst_wr_addr",  32'(bram_wr_addr), 32'd0);
        check("rst_wr_data",  32'(bram_wr_data), 32'd0);
        check("rst_start",    32'(tx_start_stb), 32'd0);
        check("rst_tx_len",   32'(tx_len),       32'd0);
        check("rst_drop_cnt", 32'(drop_cnt),     32'd0);
        rst = 1'b0;
        step();

        launch_normal(11'd1022, 11'd1022, 1'b0);
        check("tx_len_held", 32'(tx_len), 32'd1022);
        launch_normal(11'd20,   11'd60,   1'b0);
        launch_normal(11'd2000, 11'd1024, 1'b0);
        launch_normal(11'd59,   11'd60,   1'b0);
        launch_normal(11'd1025, 11'd1024, 1'b0);
        launch_normal(11'd1024, 11'd1024, 1'b1);
        check("drop_at_done_cnt", 32'(drop_cnt), 32'd1);
        check("drop_at_done_idle", 32'(busy), 32'd0);

        // tx_busy held high across the header and 100 further cycles
        tx_busy = 1'b1;
        s0 = n_start;
        d0 = n_done;
        push_frame(11'd100);
        send_req(11'd100);
        while (cyc < t_req + 14) step();
        for (int i = 0; i < 100; i++) begin
            step();
            check("busy_hold", 32'(busy), 32'd1);
        end
        check("no_start_while_txbusy", 32'(n_start), 32'(s0));
        f = cyc;
        tx_busy = 1'b0;
        wait_start(s0, 5);
        check("start_after_fall", 32'(start_cyc - f), 32'd1);
        // tx_busy never rises: launcher must time out on its own
        wait_done(d0, 300);
        check("timeout_latency", 32'(done_cyc - start_cyc), 32'd256);
        check("timeout_idle", 32'(busy), 32'd0);
        exp_seq++;
        step();

        // one accepted request followed by 300 requests while busy
        tx_busy = 1'b1;
        s0 = n_start;
        d0 = n_done;
        push_frame(11'd200);
        step();
        req_stb = 1'b1;
        req_len = 11'd200;
        t_req   = cyc;
        repeat (301) step();
        req_stb = 1'b0;
        step();
        check("drop_saturated", 32'(drop_cnt), 32'd255);
        check("no_start_during_drops", 32'(n_start), 32'(s0));
        tx_busy = 1'b0;
        wait_start(s0, 5);
        tx_busy = 1'b1;
        wait_done(d0, 10);
        exp_seq++;
        step();
        tx_busy = 1'b0;
        repeat (30) step();
        check("single_launch", 32'(n_start), 32'(s0 + 1));
        check("drop_still_sat", 32'(drop_cnt), 32'd255);

        // reset while header byte 5 is on the bus
        s0 = n_start;
        push_frame(11'd100);
        send_req(11'd100);
        while (cyc < t_req + 6) step();
        check("byte5_on_bus", 32'(bram_wr_addr), 32'd5);
        rst = 1'b1;
        step();
        check("abort_wr_en", 32'(bram_wr_en), 32'd0);
        check("abort_busy",  32'(busy),       32'd0);
        check("abort_drop",  32'(drop_cnt),   32'd0);
        rst = 1'b0;
        exp_wr.delete();
        exp_len.delete();
        exp_seq = 16'd0;
        repeat (30) step();
        check("abort_no_start", 32'(n_start), 32'(s0));

        launch_normal(11'd300, 11'd300, 1'b0);
        launch_normal(11'd60,  11'd60,  1'b0);
        repeat (5) step();
        check("queue_drained", 32'(exp_wr.size() + exp_len.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eth_frame_launcher.md
Name: eth_frame_launcher

Overview:
- Sits between the sender's PCM-packing state machine and eth_tx2.
- On a frame-ready strobe, writes the 14-byte Ethernet header into the byte-wide eth BRAM (addresses 0..13), then waits for the transmitter to go idle, then issues the start strobe with a clamped frame length.
- Counts frames that are requested while it is busy and then dropped.

Parameters:
- DST_MAC, 48'hFFFFFFFFFFFF, destination MAC written to bytes 0..5 (byte 0 = [47:40]).
- SRC_MAC, 48'h020000000001, source MAC written to bytes 6..11 (byte 6 = [47:40]).
- ETHERTYPE, 16'h88B5, written to bytes 12..13 (byte 12 = [15:8]).
- MIN_LEN, 60, minimum tx_len issued.
- MAX_LEN, 1024, maximum tx_len issued (BRAM size).
- START_TIMEOUT, 255, cycles to wait for tx_busy to rise after start.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_stb  in  1  frame-ready pulse; payload already in BRAM from byte 14
- req_len  in  11  total frame length in bytes, header included
- busy  out  1  high whenever state != IDLE
- done_stb  out  1  one-cycle pulse on return to IDLE after a launch
- bram_wr_en  out  1  header byte write enable
- bram_wr_addr  out  10  header byte address
- bram_wr_data  out  8  header byte
- tx_start_stb  out  1  to eth_tx2 start
- tx_len  out  11  to eth_tx2 length
- tx_busy  in  1  from eth_tx2 busy
- drop_cnt  out  8  saturating count of dropped requests

Behaviour:
- Reset: all outputs 0, state IDLE, internal length latch 0; sequence counter 0 (when the optional feature is enabled). Reset mid-operation aborts immediately: no further BRAM writes, no tx_start_stb.
- All outputs are registered.
- IDLE: req_stb latches clamp(req_len) = max(MIN_LEN, min(req_len, MAX_LEN)) → HDR with byte index 0.
- HDR: one byte per cycle.
  - bram_wr_en=1, bram_wr_addr=index, bram_wr_data=header[index].
  - Bytes are written in order 0..13, big-endian fields.
  - After index 13 is written → WAIT_IDLE; bram_wr_en drops to 0 in the cycle following byte 13.
- WAIT_IDLE: when tx_busy==0 → START.
- START: tx_start_stb=1 for exactly one cycle, tx_len = latched length (held until the next launch) → WAIT_BUSY.
- WAIT_BUSY:
  - tx_busy==1 → IDLE with done_stb=1.
  - Otherwise, after START_TIMEOUT cycles without tx_busy → IDLE with done_stb=1 (timeout is not an error).
- Timing: req_stb sampled at cycle T gives header writes at T+1..T+14, WAIT_IDLE at T+15, and tx_start_stb at T+16 at the earliest (tx_busy low).
- req_stb while busy=1: ignored, drop_cnt += 1, saturating at 255.
  - req_stb in the same cycle as done_stb is also dropped; it is accepted only from IDLE.
- Header writes never touch addresses ≥14.
- The parent muxes the BRAM write port to this block whenever busy=1; the parent must not write the BRAM in that window.

Optional Feature:
- Macro: ETH_FRAME_LAUNCHER_SEQ_EN.
- When defined:
  - Bytes 10..11 carry a 16-bit frame sequence number (byte 10 = [15:8]) instead of SRC_MAC[15:0].
  - The counter increments by 1 at each tx_start_stb and wraps 16'hFFFF → 0.
  - The counter is not incremented on dropped requests.
- When undefined: bytes 10..11 = SRC_MAC[15:0] and no counter logic exists.

Test Plan:
- Reset, req_stb with req_len=1022, tx_busy=0 → writes at T+1..T+14 with addr 0..13 and data FF×6,02,00,00,00,00,01,88,B5; tx_start_stb at T+16 with tx_len=1022; done_stb when tx_busy rises.
- req_len=20 → tx_len=60. req_len=2000 → tx_len=1024.
- tx_busy held 1 for 100 cycles after the header is written → no tx_start_stb until the cycle after tx_busy falls; busy stays 1 throughout.
- 300 extra req_stb pulses while busy → drop_cnt=255 (saturated); exactly one launch occurs.
- tx_busy never rises after start → return to IDLE after 255 cycles with done_stb=1.
- With ETH_FRAME_LAUNCHER_SEQ_EN: three launches → bytes 10..11 = 00 00, 00 01, 00 02. Counter preset near wrap (65536 launches, or a forced value) → FF FF then 00 00. Reset asserted at header byte 5 → bram_wr_en=0 in the next cycle, no tx_start_stb, sequence counter 0.
